serial_addsub_multi: RTL

- Parametrised multi-bit-per-cycle serial adder/subtractor; next generation of the team's 32-bit bit-serial adder.
- Processes DIGIT_W bits per clock over WIDTH-bit operands.
- Adds subtract mode, chained carry/borrow input, signed overflow, busy/done handshake and held result registers.
- Sits as a low-area arithmetic datapath element driven by a controller FSM.

---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/serial_digit_adder.sv | 29 ++
 rtl/serial_addsub_multi.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial add/subtract datapath.
// Provides the FSM state enum, mode encodings and step-counter sizing.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Counter must be able to hold every value 0..k.
    function automatic int cnt_width(input int k);
        return (k < 1) ? 1 : $clog2(k + 1);
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT_W-bit ripple adder for one serial digit step.
// Ports: a, b, cin in; s (digit sum), cout (carry out), c_msb_in (carry into top bit).
module serial_digit_adder #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout,
    output logic               c_msb_in
);

    always_comb begin
        logic carry;
        carry    = cin;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (i == DIGIT_W - 1) begin
                c_msb_in = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_addsub_multi.sv
// Multi-bit-per-cycle serial adder/subtractor, DIGIT_W bits per clock.
// Ports: clk, rst (sync, active-low), start, mode, carry_in, operand_A/B in;
//        sum, carry_out, overflow (held results), busy, done (pulse) out.
module serial_addsub_multi
    import serial_arith_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int K  = WIDTH / DIGIT_W;
    localparam int CW = cnt_width(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if (DIGIT_W < 1 || DIGIT_W > WIDTH || (WIDTH % DIGIT_W) != 0) begin : g_bad_param
        $error("serial_addsub_multi: WIDTH must be a multiple of DIGIT_W, DIGIT_W in 1..WIDTH");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, ps_q;
    logic [WIDTH-1:0] a_d, b_d, ps_d;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, busy_q, done_q;

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_cout, dig_cmsb;

    serial_digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a        (a_q[DIGIT_W-1:0]),
        .b        (b_q[DIGIT_W-1:0]),
        .cin      (c_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    // Operands drain from the LSB end; the result fills in from the MSB end
    // so that after K steps the partial sum is aligned.
    always_comb begin
        a_d  = a_q >> DIGIT_W;
        b_d  = b_q >> DIGIT_W;
        ps_d = (ps_q >> DIGIT_W) | (WIDTH'(dig_s) << (WIDTH - DIGIT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow.
                        a_q     <= operand_A;
                        b_q     <= (mode == MODE_SUB) ? ~operand_B : operand_B;
                        c_q     <= carry_in ^ (mode == MODE_SUB);
                        ps_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    ps_q  <= ps_d;
                    c_q   <= dig_cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= ps_d;
                        cout_q  <= dig_cout;
                        ovf_q   <= dig_cmsb ^ dig_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
